// File: rtl/cache_req_pkg.sv
// Shared types for the cache request queue: FSM states, rw encoding and the
// default-width request record.
package cache_req_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int REQ_ADDR_W = 32;
   localparam int REQ_DATA_W = 32;

   // Request record at the default cache widths; the queue builds its own
   // parameter-sized copy with the same field order.
   typedef struct packed {
      logic                  rw;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] data;
   } req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push while full and pop while
// empty are ignored.
module req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/cache_req_queue.sv
// Buffers CPU requests and issues them one at a time to the direct-mapped
// cache, returning read data, hit status and measured latency.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no request in flight; pops the FIFO head when one exists
//   ST_ISSUE | valid_req driven for ISSUE_CYCLES cycles
//   ST_WAIT  | request held stable, waiting for cache_ready
//   ST_RESP  | one-cycle rsp_valid with captured read data/hit/latency
module cache_req_queue
   import cache_req_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int ISSUE_CYCLES = 2,
   parameter int LAT_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic              rsp_rw,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_hit,
   output logic [LAT_W-1:0]  rsp_latency,
   output logic              valid_req,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dataIn,
   input  logic              cache_ready,
   input  logic              hit,
   input  logic              miss,
   input  logic [DATA_W-1:0] dataOut
);

   localparam int TW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_e      state;
   state_e      state_nx;
   entry_t      fifo_din;
   entry_t      fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   logic        busy;
   logic        done;
   logic [TW-1:0]    issue_tmr;
   logic [LAT_W-1:0] lat;

   assign fifo_din  = '{rw: req_rw, addr: req_addr, data: req_data};
   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && req_ready;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

   req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy = (state == ST_ISSUE) || (state == ST_WAIT);
   assign done = busy && cache_ready;

   // An early completion pulls valid_req down in the same cycle.
   assign valid_req = (state == ST_ISSUE) && !cache_ready;
   assign rsp_valid = (state == ST_RESP);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (!fifo_empty) state_nx = ST_ISSUE;
         ST_ISSUE: begin
            if (cache_ready)          state_nx = ST_RESP;
            else if (issue_tmr == '0) state_nx = ST_WAIT;
         end
         ST_WAIT:  if (cache_ready) state_nx = ST_RESP;
         ST_RESP:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Down-counter for the remaining valid_req cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_tmr <= '0;
      end else if (fifo_pop) begin
         issue_tmr <= TW'(ISSUE_CYCLES - 1);
      end else if (state == ST_ISSUE && issue_tmr != '0) begin
         issue_tmr <= issue_tmr - 1'b1;
      end
   end

   // Latency counts from the first valid_req cycle and saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat <= '0;
      end else if (fifo_pop) begin
         lat <= '0;
      end else if (busy && lat != '1) begin
         lat <= lat + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw     <= RW_WRITE;
         addr   <= '0;
         dataIn <= '0;
      end else if (fifo_pop) begin
         rw     <= fifo_dout.rw;
         addr   <= fifo_dout.addr;
         dataIn <= fifo_dout.data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_rw      <= 1'b0;
         rsp_data    <= '0;
         rsp_hit     <= 1'b0;
         rsp_latency <= '0;
      end else if (done) begin
         rsp_rw      <= rw;
         rsp_data    <= (rw == RW_READ) ? dataOut : '0;
         rsp_hit     <= hit;
         rsp_latency <= lat;
      end
   end

   // hit and miss must be complementary on completion; rsp_hit follows hit regardless.
   a_hit_miss_onehot : assert property (@(posedge clk) disable iff (!reset)
      done |-> (hit ^ miss));

endmodule

// File: doc/cache_req_queue.md
Name: cache_req_queue

Overview:
- Upstream stage of the direct-mapped cache top (main); sits between the CPU-side requester and the cache's valid_req/rw/addr/dataIn/cache_ready/hit/miss/dataOut interface.
- Buffers CPU read/write requests in a small FIFO and issues them to the cache one at a time.
- Holds valid_req for a fixed number of cycles, waits for completion, and returns read data, hit/miss status and measured latency to the CPU.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 32, address width.
- DATA_W, 32, CPU data width.
- ISSUE_CYCLES, 2, cycles valid_req is held per request; ≥1.
- LAT_W, 8, latency counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_valid  in  1  CPU request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  ADDR_W  byte address.
- req_data  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rw  out  1  rw of the completed request.
- rsp_data  out  DATA_W  read data; 0 for writes.
- rsp_hit  out  1  1=hit, 0=miss.
- rsp_latency  out  LAT_W  cycles from first valid_req cycle to completion, saturating.
- valid_req  out  1  to cache.
- rw  out  1  to cache.
- addr  out  ADDR_W  to cache.
- dataIn  out  DATA_W  to cache.
- cache_ready  in  1  cache completion pulse, one cycle.
- hit  in  1  valid while cache_ready=1.
- miss  in  1  valid while cache_ready=1.
- dataOut  in  DATA_W  read data, valid while cache_ready=1.

Behaviour:
- Reset values:
  - All outputs 0, except req_ready=1.
  - FIFO empty, pointers 0, FSM in IDLE.
- FIFO:
  - Push when req_valid && req_ready.
  - Pop on the IDLE→ISSUE transition.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Push while full is dropped (req_ready=0 forbids it).
  - Pointers are log2(DEPTH)+1 bits; wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If FIFO is not empty, pop the head into the issue registers (rw/addr/dataIn) and go to ISSUE.
  - A request pushed into an empty FIFO is popped the following cycle (1-cycle minimum FIFO latency).
- ISSUE:
  - valid_req=1 for exactly ISSUE_CYCLES cycles; then WAIT.
  - Latency counter is cleared on ISSUE entry and increments every cycle in ISSUE and WAIT.
  - If cache_ready arrives during ISSUE, treat it as completion and go to RESP immediately; valid_req drops that cycle.
- WAIT:
  - valid_req=0; rw/addr/dataIn are held stable.
  - On cache_ready, capture hit and dataOut (only if rw=1, else 0) and the latency counter, then go to RESP.
- RESP:
  - rsp_valid=1 for one cycle with the captured values; then IDLE.
  - Back-to-back issue gap is therefore ≥1 idle cycle: RESP→IDLE→ISSUE.
- Latency counter saturates at 2^LAT_W−1.
- hit && miss both 1, or both 0 with cache_ready: rsp_hit follows hit; this is flagged by an assertion, not handled.
- cache_ready outside ISSUE/WAIT is ignored.
- Reset mid-operation:
  - The in-flight request and all queued entries are discarded; valid_req drops asynchronously.
  - No response is emitted.

Decomposition:
- Package cache_req_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - RW_READ=1, RW_WRITE=0;
  - request struct {rw, addr, data}.
- One sub-module: req_fifo (parameterised sync FIFO, DEPTH × (1+ADDR_W+DATA_W), push/pop/full/empty, async active-low reset).

Test Plan:
- Reset asserted low mid-stream → all outputs 0, req_ready=1, no rsp_valid after release.
- Single read, addr 0x20, cache_ready 5 cycles after first valid_req with hit=0 and dataOut=0xABCD → valid_req high exactly 2 cycles; rsp_valid one cycle with rsp_rw=1, rsp_data=0xABCD, rsp_hit=0, rsp_latency=5.
- Write to 0x10 with data 0x1FF, then read 0x10 with hit=1 and dataOut=0x1FF → cache sees the write first with dataIn=0x1FF; responses in order: rsp_data 0 then 0x1FF, rsp_hit 1 on the read.
- Push 5 requests back-to-back with cache stalled → req_ready low after the 4th accepted plus 1 popped; all 5 issued in order: addr 0x20, 0x40, 0x20, 0x10, 0x4010.
- cache_ready during the second ISSUE cycle → valid_req drops that cycle; rsp_valid the next cycle; rsp_latency=1.
- Cache withholds cache_ready for 300 cycles → rsp_latency=255 (saturated); FSM stays in WAIT until cache_ready.
